// File: rtl/sobel_edge_3x3.sv
// sobel_edge_3x3: 3x3 Sobel gradient magnitude over a raster gray stream, LATENCY=4
// Ports: clk/rst (async active-high); in_data {R,G,B} with gray in the low channel,
// in_vcnt/in_hcnt raster coordinates, in_vde active flag (line-buffer write enable);
// out_data saturated |Gx|+|Gy| on all three channels, out_vcnt/out_hcnt inputs delayed
// by 4, out_vde active flag derived from the delayed coordinates.
module sobel_edge_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE = -1,
  parameter int V_ACTIVE = -1,
  parameter int H_FRAME = -1,
  parameter int V_FRAME = -1,
  parameter int RAM_SIZE = 4096,
  localparam int VW = $clog2(V_FRAME),
  localparam int HW = $clog2(H_FRAME)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH*3-1:0] in_data,
  input  logic [VW-1:0]           in_vcnt,
  input  logic [HW-1:0]           in_hcnt,
  input  logic                    in_vde,
  output logic [DATA_WIDTH*3-1:0] out_data,
  output logic [VW-1:0]           out_vcnt,
  output logic [HW-1:0]           out_hcnt,
  output logic                    out_vde
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 3;
  localparam int AW = $clog2(RAM_SIZE);
  localparam logic [DW-1:0] MAXV = '1;
  logic [DW-1:0] lb1 [RAM_SIZE];
  logic [DW-1:0] lb2 [RAM_SIZE];
  logic [AW-1:0] addr;
  logic [DW-1:0] gray;
  logic unused_hi;
  logic [DW-1:0] rd1, rd2, g1;
  logic [DW-1:0] w [3][3];
  logic signed [SW-1:0] gx, gy;
  logic [VW-1:0] v1, v2, v3;
  logic [HW-1:0] h1, h2, h3;
  logic s1, s2, s3;
  logic [SW-1:0] ax, ay, mag;
  logic [DW-1:0] sat;
  logic valid;
  assign addr = AW'(in_hcnt);
  assign gray = in_data[DW-1:0];
  assign unused_hi = ^in_data[3*DW-1:DW];
  function automatic logic signed [SW-1:0] x(input logic [DW-1:0] p);
    return signed'({3'b000, p});
  endfunction
  // Read-first: both RAMs shift down one row at the same address in one edge.
  always_ff @(posedge clk) begin
    if (in_vde) begin
      lb1[addr] <= gray;
      lb2[addr] <= lb1[addr];
    end
  end
  always_comb begin
    ax = gx[SW-1] ? -gx : gx;
    ay = gy[SW-1] ? -gy : gy;
    mag = ax + ay;
    sat = (mag > {3'b000, MAXV}) ? MAXV : mag[DW-1:0];
    valid = s3 && (32'(v3) >= 2) && (32'(v3) < V_ACTIVE) && (32'(h3) >= 2) && (32'(h3) < H_ACTIVE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rd1, rd2, g1, v1, v2, v3, h1, h2, h3, s1, s2, s3} <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
      gx <= '0;
      gy <= '0;
      out_data <= '0;
      out_vcnt <= '0;
      out_hcnt <= '0;
      out_vde <= 1'b0;
    end else begin
      rd1 <= lb1[addr];
      rd2 <= lb2[addr];
      g1 <= gray;
      v1 <= in_vcnt;
      h1 <= in_hcnt;
      // Sticky once the first frame start is seen; stale rows before it never validate.
      s1 <= s1 | (in_vcnt == '0 && in_hcnt == '0);
      w[0][2] <= rd2;
      w[1][2] <= rd1;
      w[2][2] <= g1;
      for (int r = 0; r < 3; r++) begin
        w[r][1] <= w[r][2];
        w[r][0] <= w[r][1];
      end
      v2 <= v1;
      h2 <= h1;
      s2 <= s1;
      gx <= (x(w[0][2]) + (x(w[1][2]) <<< 1) + x(w[2][2])) - (x(w[0][0]) + (x(w[1][0]) <<< 1) + x(w[2][0]));
      gy <= (x(w[2][0]) + (x(w[2][1]) <<< 1) + x(w[2][2])) - (x(w[0][0]) + (x(w[0][1]) <<< 1) + x(w[0][2]));
      v3 <= v2;
      h3 <= h2;
      s3 <= s2;
      out_data <= {3{valid ? sat : '0}};
      out_vcnt <= v3;
      out_hcnt <= h3;
      out_vde <= (32'(v3) < V_ACTIVE) && (32'(h3) < H_ACTIVE);
    end
  end
endmodule

// File: tb/tb_sobel_edge_3x3.sv
// tb_sobel_edge_3x3: directed frames checking coordinates, validity and Sobel magnitudes
module tb_sobel_edge_3x3;
  localparam int HA = 8, VA = 6, HF = 10, VF = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] in_data = '0;
  logic [2:0] in_vcnt = '0;
  logic [3:0] in_hcnt = '0;
  logic in_vde = 1'b0;
  logic [23:0] out_data;
  logic [2:0] out_vcnt;
  logic [3:0] out_hcnt;
  logic out_vde;
  typedef struct {int v; int h; int d;} ent_t;
  ent_t hist [4];
  int n_vec = 0;
  int n_err = 0;
  bit synced = 1'b0;
  bit in_rst = 1'b1;
  always #5 clk = ~clk;
  sobel_edge_3x3 #(
    .DATA_WIDTH(8), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_FRAME(HF), .V_FRAME(VF), .RAM_SIZE(4096)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .in_vde(in_vde),
    .out_data(out_data), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt), .out_vde(out_vde)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // Patterns: 0 uniform 100, 1 impulse 40 at (3,3), 2 edge 10|20, 3 edge 0|255; blanking carries 255.
  function automatic int pix(input int pat, input int v, input int h);
    if (v >= VA || h >= HA) return 255;
    case (pat)
      0: return 100;
      1: return (v == 3 && h == 3) ? 40 : 0;
      2: return h < 4 ? 10 : 20;
      default: return h < 4 ? 0 : 255;
    endcase
  endfunction
  // Expected magnitude at out coordinate (v,h), worked out by hand for each pattern.
  function automatic int expf(input int pat, input int v, input int h);
    if (!(v >= 2 && v < VA && h >= 2 && h < HA)) return 0;
    case (pat)
      0: return 0;
      1: return (v >= 3 && v <= 5 && h >= 3 && h <= 5 && !(v == 4 && h == 4)) ? 80 : 0;
      2: return (h == 4 || h == 5) ? 40 : 0;
      default: return (h == 4 || h == 5) ? 255 : 0;
    endcase
  endfunction
  task automatic chk_zero(input string tag);
    check({tag, " vcnt"}, 32'(out_vcnt), 0);
    check({tag, " hcnt"}, 32'(out_hcnt), 0);
    check({tag, " vde"}, 32'(out_vde), 0);
    check({tag, " data"}, 32'(out_data), 0);
  endtask
  task automatic step(input int v, input int h, input int pat, input bit rst_on, input bit rst_off);
    ent_t e;
    logic [7:0] d8;
    @(posedge clk);
    #1;
    if (in_rst) chk_zero($sformatf("in-reset at in(%0d,%0d)", v, h));
    else begin
      e = hist[3];
      d8 = 8'(e.d);
      check($sformatf("vcnt for in(%0d,%0d)", e.v, e.h), 32'(out_vcnt), 32'(e.v));
      check($sformatf("hcnt for in(%0d,%0d)", e.v, e.h), 32'(out_hcnt), 32'(e.h));
      check($sformatf("vde for in(%0d,%0d)", e.v, e.h), 32'(out_vde), 32'(e.v < VA && e.h < HA));
      check($sformatf("data for in(%0d,%0d)", e.v, e.h), 32'(out_data), {8'h00, d8, d8, d8});
    end
    if (rst_on) begin
      rst = 1'b1;
      in_rst = 1'b1;
      #1;
      chk_zero("async reset");
      synced = 1'b0;
      for (int i = 0; i < 4; i++) hist[i] = '{0, 0, 0};
    end
    if (rst_off) begin
      rst = 1'b0;
      in_rst = 1'b0;
    end
    in_vcnt = 3'(v);
    in_hcnt = 4'(h);
    in_data = {3{8'(pix(pat, v, h))}};
    in_vde = (v < VA && h < HA);
    if (!in_rst) begin
      if (v == 0 && h == 0) synced = 1'b1;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = '{v, h, synced ? expf(pat, v, h) : 0};
    end
  endtask
  task automatic frame(input int pat, input bit first, input bit mid_rst);
    for (int v = 0; v < VF; v++)
      for (int h = 0; h < HF; h++)
        step(v, h, pat, mid_rst && v == 3 && h == 5, (first && v == 0 && h == 0) || (mid_rst && v == 3 && h == 8));
  endtask
  initial begin
    for (int i = 0; i < 4; i++) hist[i] = '{0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset state");
    frame(0, 1'b1, 1'b0);
    frame(0, 1'b0, 1'b0);
    frame(1, 1'b0, 1'b0);
    frame(1, 1'b0, 1'b0);
    frame(2, 1'b0, 1'b0);
    frame(3, 1'b0, 1'b0);
    frame(2, 1'b0, 1'b1);
    frame(2, 1'b0, 1'b0);
    for (int h = 0; h < 4; h++) step(0, h, 0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sobel_edge_3x3.md
Name: sobel_edge_3x3

Overview:
- Downstream stage of the gray-scaling image processor. Consumes its replicated-gray pixel stream and raster coordinates.
- Buffers two previous lines and forms a 3x3 window per pixel. Computes Sobel gradient magnitude |Gx|+|Gy|, saturated, and re-emits it as a replicated-gray stream.
- Coordinates are delayed to stay aligned with the data.
- Border pixels, and pixels before the first frame start after reset, are forced to 0.

Parameters:
- DATA_WIDTH, 8, bits per colour channel.
- H_ACTIVE, -1, active pixels per line; must be set.
- V_ACTIVE, -1, active lines per frame; must be set.
- H_FRAME, -1, total pixels per line including blanking; must be set.
- V_FRAME, -1, total lines per frame including blanking; must be set.
- RAM_SIZE, 4096, depth of each line buffer; must be >= H_ACTIVE.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH*3  pixel {R,G,B}; only bits [DATA_WIDTH-1:0] are used (gray).
- in_vcnt  in  $clog2(V_FRAME)  input line coordinate.
- in_hcnt  in  $clog2(H_FRAME)  input pixel coordinate.
- in_vde  in  1  input active flag; write enable for the line buffers.
- out_data  out  DATA_WIDTH*3  edge magnitude replicated on 3 channels.
- out_vcnt  out  $clog2(V_FRAME)  in_vcnt delayed by LATENCY.
- out_hcnt  out  $clog2(H_FRAME)  in_hcnt delayed by LATENCY.
- out_vde  out  1  registered: (out_vcnt<V_ACTIVE)&(out_hcnt<H_ACTIVE).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: out_data=0, out_vcnt=0, out_hcnt=0, out_vde=0. All pipeline registers are 0 and the sync flag is 0. Line-buffer RAM contents are not reset.
- Latency: fixed LATENCY=4 cycles from in_* to out_*. There is no handshake or stall; one pixel per clock, including blanking.
- Line buffers: two RAMs, lb1 and lb2, each RAM_SIZE x DATA_WIDTH, addressed by in_hcnt, read-first.
  - When in_vde=1: lb1[h] <= gray and lb2[h] <= old lb1[h].
  - Read data at address h gives row v-1 (lb1) and row v-2 (lb2) of the same column.
  - No write when in_vde=0.
- Window: for input coordinate (v,h), the window W[r][c] (r,c = 0..2) holds pixels at rows v-2+r and columns h-2+c. A three-deep column shift register feeds it.
- Arithmetic: signed width DATA_WIDTH+3.
  - Gx = (W02+2W12+W22) - (W00+2W10+W20).
  - Gy = (W20+2W21+W22) - (W00+2W01+W02).
  - mag = |Gx|+|Gy|, range 0..8*(2^DATA_WIDTH-1).
  - Saturate to 2^DATA_WIDTH-1.
- Output meaning: out_data at out coordinate (v,h) is the magnitude centred at pixel (v-1,h-1).
- Validity: the result is valid iff 2<=v<V_ACTIVE, 2<=h<H_ACTIVE, and the sync flag is 1. Otherwise out_data=0.
- Sync flag: set on the cycle the input shows in_vcnt==0 && in_hcnt==0. The flag is pipelined with the data; it stays set until reset.
  - Consequence: after reset, including reset mid-frame, out_data=0 until the pipelined frame start reaches the output.
  - This prevents stale line-buffer rows from producing output.
- Coordinate handling:
  - Wrap-around of in_hcnt/in_vcnt is passed through unchanged.
  - out_vde during blanking is 0.
  - Columns h=0,1 at the start of each line are always 0. Window data straddling the previous line's end is therefore never emitted.
- Reset mid-operation: outputs drop to reset values asynchronously. Behaviour resumes per the sync-flag rule.

Test Plan:
Common setup: H_ACTIVE=8, V_ACTIVE=6, H_FRAME=10, V_FRAME=8, DATA_WIDTH=8. Frames start from reset.
1. Uniform frame, all pixels 100 -> out_data=0 at every coordinate in frames 1 and 2.
   - out_vcnt/out_hcnt equal the input coordinates exactly 4 cycles earlier.
   - out_vde is 1 only for h<8, v<6.
2. Impulse: pixel (3,3)=40, all other pixels 0 -> in frame 2, out_data=80 at out coords (3,3) and (4,3).
   - Centre (2,2): |Gx|=40, |Gy|=40 -> 80.
   - Centre (3,2): Gx=+80, Gy=0 -> 80.
   - out coord (4,4) gives 0.
   - Each value is observed 4 cycles after the input presents that coordinate.
3. Vertical edge: columns 0-3 = 10, columns 4-7 = 20 -> out_data=40 at out_hcnt 4 and 5 for v=2..5.
   - 0 at other h in 2..7.
   - 0 at h<2 and v<2.
4. Saturation: columns 0-3 = 0, columns 4-7 = 255 -> out_data=255 (raw 1020 clamped) at out_hcnt 4 and 5.
   - All three channels of out_data are equal.
5. Reset mid-frame: assert rst for 3 cycles at input (3,5) of frame 2.
   - Outputs are 0 immediately (asynchronously).
   - out_data stays 0 for the remainder of frame 2, even with the edge pattern applied.
   - Frame 3 reproduces the scenario-3 values exactly.
6. Blanking: drive in_data=255 with in_vde=0 for h>=8 -> line-buffer contents are unchanged.
   - Next-row results match scenario 3.
   - out_vde=0 and out_data=0 at out_hcnt 8 and 9.
